// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32 multi-cycle control sequencer:
// states, opcodes, ALU controls and fault causes.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      START    = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      MEM_ADDR = 4'd3,
      MEM_RD   = 4'd4,
      MEM_WB   = 4'd5,
      MEM_WR   = 4'd6,
      EXEC_R   = 4'd7,
      EXEC_I   = 4'd8,
      ALU_WB   = 4'd9,
      BRANCH   = 4'd10,
      FAULT    = 4'd11
   } state_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_BRCMP  = 2'b01;
   localparam logic [1:0] ALU_FUNCT  = 2'b10;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   // States that hold a memory access open until mem_ready.
   function automatic logic is_waiting(state_e s);
      return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
   endfunction

   function automatic logic is_retire(state_e s);
      return (s == MEM_WB) || (s == MEM_WR) ||
             (s == ALU_WB) || (s == BRANCH);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of an open memory access and
// flags a timeout on the MEM_TIMEOUT-th one; MEM_TIMEOUT=0 disables it.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic waiting,
   input  logic mem_ready,
   output logic timeout
);

   generate
      if (MEM_TIMEOUT == 0) begin : g_off
         logic unused_in;
         assign unused_in = ^{clk, reset, waiting, mem_ready};
         assign timeout   = 1'b0;
      end else begin : g_on
         localparam int CW =
            (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
         logic [CW-1:0] cnt_q;
         logic [CW-1:0] cnt_d;
         logic          stall;

         assign stall = waiting && !mem_ready;

         always_comb begin
            cnt_d   = '0;
            timeout = stall &&
                      (cnt_q == CW'(MEM_TIMEOUT - 1));
            // The timeout cycle leaves the state, so clear.
            if (stall && !timeout) begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32 control sequencer; define PERF_CNT_EN to build
// the cycles/instret performance counters.
module multicycle_ctrl_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             pc_source,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             fault,
   output logic [1:0]       fault_cause,
   output logic [CNT_W-1:0] instret,
   output logic [CNT_W-1:0] cycles
);

   state_e     state_q;
   state_e     state_d;
   logic [6:0] opc_q;
   logic [6:0] opc_d;
   logic [1:0] cause_q;
   logic [1:0] cause_d;
   logic       timeout;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .waiting   (is_waiting(state_q)),
      .mem_ready (mem_ready),
      .timeout   (timeout)
   );

   always_comb begin
      state_d       = state_q;
      opc_d         = opc_q;
      cause_d       = cause_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_RS2;
      alu_op        = ALU_ADD;
      fault         = 1'b0;
      unique case (state_q)
         START: state_d = FETCH;
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            if (timeout) begin
               state_d = FAULT;
               cause_d = CAUSE_TIMEOUT;
            end else if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = DECODE;
            end
         end
         DECODE: begin
            alu_src_b = SRCB_IMM;
            opc_d     = opcode;
            case (opcode)
               OPC_LOAD,
               OPC_STORE:  state_d = MEM_ADDR;
               OPC_RTYPE:  state_d = EXEC_R;
               OPC_ITYPE:  state_d = EXEC_I;
               OPC_BRANCH: state_d = BRANCH;
               default: begin
                  state_d = FAULT;
                  cause_d = CAUSE_ILLEGAL;
               end
            endcase
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = (opc_q == OPC_LOAD) ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (timeout) begin
               state_d = FAULT;
               cause_d = CAUSE_TIMEOUT;
            end else if (mem_ready) begin
               state_d = MEM_WB;
            end
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = FETCH;
         end
         MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (timeout) begin
               state_d = FAULT;
               cause_d = CAUSE_TIMEOUT;
            end else if (mem_ready) begin
               state_d = FETCH;
            end
         end
         EXEC_R: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_RS2;
            alu_op    = ALU_FUNCT;
            state_d   = ALU_WB;
         end
         EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = ALU_WB;
         end
         ALU_WB: begin
            reg_write = 1'b1;
            state_d   = FETCH;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_BRCMP;
            pc_write_cond = 1'b1;
            pc_source     = 1'b1;
            state_d       = FETCH;
         end
         FAULT: fault = 1'b1;
         default: state_d = FAULT;
      endcase
   end

   assign fault_cause = cause_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= START;
         opc_q   <= '0;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
         cause_q <= cause_d;
      end
   end

`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] cyc_q;
   logic [CNT_W-1:0] cyc_d;
   logic [CNT_W-1:0] ret_q;
   logic [CNT_W-1:0] ret_d;

   always_comb begin
      cyc_d = cyc_q;
      ret_d = ret_q;
      if (state_q != FAULT) begin
         cyc_d = cyc_q + 1'b1;
      end
      if (state_d == FETCH && is_retire(state_q)) begin
         ret_d = ret_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         ret_q <= ret_d;
      end
   end

   assign cycles  = cyc_q;
   assign instret = ret_q;
`else
   assign cycles  = '0;
   assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed scoreboard bench for multicycle_ctrl_fsm, plus a second
// instance with MEM_TIMEOUT=0 for the no-timeout case.
module tb_multicycle_ctrl_fsm;
   import riscv_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_ready;
   logic [6:0]  opcode;

   logic        pc_write, pc_write_cond, pc_source, i_or_d;
   logic        mem_read, mem_write, ir_write, reg_write;
   logic        mem_to_reg, alu_src_a, fault;
   logic [1:0]  alu_src_b, alu_op, fault_cause;
   logic [31:0] instret, cycles;

   logic        z_pcw, z_pwc, z_psrc, z_iord, z_mrd, z_mwr;
   logic        z_irw, z_rw, z_m2r, z_srca, z_flt;
   logic [1:0]  z_srcb, z_aop, z_cause;
   logic [31:0] z_ret, z_cyc;

   logic [16:0] obs;

   int          ncmp = 0;
   int          nfail = 0;
   logic [16:0] q[$];
   int          m_cyc;
   int          m_ret;
   logic        have_prev;
   state_e      prev;
   logic [1:0]  e_cause;

   always #5 clk = ~clk;

   multicycle_ctrl_fsm #(
      .MEM_TIMEOUT (16),
      .CNT_W       (32)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .pc_source     (pc_source),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .reg_write     (reg_write),
      .mem_to_reg    (mem_to_reg),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .fault         (fault),
      .fault_cause   (fault_cause),
      .instret       (instret),
      .cycles        (cycles)
   );

   multicycle_ctrl_fsm #(
      .MEM_TIMEOUT (0),
      .CNT_W       (32)
   ) dut0 (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .pc_write      (z_pcw),
      .pc_write_cond (z_pwc),
      .pc_source     (z_psrc),
      .i_or_d        (z_iord),
      .mem_read      (z_mrd),
      .mem_write     (z_mwr),
      .ir_write      (z_irw),
      .reg_write     (z_rw),
      .mem_to_reg    (z_m2r),
      .alu_src_a     (z_srca),
      .alu_src_b     (z_srcb),
      .alu_op        (z_aop),
      .fault         (z_flt),
      .fault_cause   (z_cause),
      .instret       (z_ret),
      .cycles        (z_cyc)
   );

   assign obs = {pc_write, pc_write_cond, pc_source, i_or_d,
                 mem_read, mem_write, ir_write, reg_write,
                 mem_to_reg, alu_src_a, alu_src_b, alu_op,
                 fault, fault_cause};

   // Expected strobe vector for a state, from the control table.
   function automatic logic [16:0] exp_v(state_e s, logic mr,
                                         logic [1:0] cause);
      logic pcw, pwc, psrc, iord, mrd, mwr, irw, rw, m2r, sa, flt;
      logic [1:0] sb, op, fc;
      {pcw, pwc, psrc, iord, mrd, mwr, irw, rw, m2r, sa, flt} = '0;
      sb = 2'b00;
      op = 2'b00;
      fc = 2'b00;
      case (s)
         FETCH:    begin mrd = 1; sb = 2'b01; pcw = mr; irw = mr; end
         DECODE:   sb = 2'b10;
         MEM_ADDR: begin sa = 1; sb = 2'b10; end
         MEM_RD:   begin mrd = 1; iord = 1; end
         MEM_WB:   begin rw = 1; m2r = 1; end
         MEM_WR:   begin mwr = 1; iord = 1; end
         EXEC_R:   begin sa = 1; op = 2'b10; end
         EXEC_I:   begin sa = 1; sb = 2'b10; end
         ALU_WB:   rw = 1;
         BRANCH:   begin sa = 1; op = 2'b01; pwc = 1; psrc = 1; end
         FAULT:    begin flt = 1; fc = cause; end
         default:  ;
      endcase
      return {pcw, pwc, psrc, iord, mrd, mwr, irw, rw, m2r, sa,
              sb, op, flt, fc};
   endfunction

   function automatic void chk(string tag, logic [31:0] got,
                               logic [31:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endfunction

   task automatic chk_cnt(input string tag);
`ifdef PERF_CNT_EN
      chk({tag, "_cycles"}, cycles, m_cyc);
      chk({tag, "_instret"}, instret, m_ret);
`else
      chk({tag, "_cycles"}, cycles, 32'd0);
      chk({tag, "_instret"}, instret, 32'd0);
`endif
   endtask

   // One clock: drive, score, compare, advance to next negedge.
   task automatic step(input string tag, input state_e s,
                       input logic mr);
      logic [16:0] e;
      mem_ready = mr;
      q.push_back(exp_v(s, mr, e_cause));
      if (have_prev) begin
         if (prev != FAULT) m_cyc++;
         if (s == FETCH && prev inside {MEM_WB, MEM_WR, ALU_WB, BRANCH})
            m_ret++;
      end
      have_prev = 1'b1;
      prev      = s;
      #1;
      e = q.pop_front();
      chk(tag, {15'd0, obs}, {15'd0, e});
      chk_cnt(tag);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      chk("rst_strobes", {15'd0, obs}, 32'd0);
      chk("rst_cycles", cycles, 32'd0);
      chk("rst_instret", instret, 32'd0);
      reset     = 1'b0;
      have_prev = 1'b0;
      m_cyc     = 0;
      m_ret     = 0;
      e_cause   = 2'b00;
   endtask

   task automatic fetch(input int waits);
      for (int i = 0; i < waits; i++) step("fetch_wait", FETCH, 1'b0);
      step("fetch", FETCH, 1'b1);
   endtask

   initial begin
      reset     = 1'b1;
      mem_ready = 1'b0;
      opcode    = '0;
      have_prev = 1'b0;
      m_cyc     = 0;
      m_ret     = 0;
      e_cause   = 2'b00;
      @(negedge clk);
      do_reset();
      step("start", START, 1'b1);

      opcode = OPC_RTYPE;
      fetch(0);
      step("r_decode", DECODE, 1'b1);
      step("r_exec", EXEC_R, 1'b1);
      step("r_wb", ALU_WB, 1'b1);

      opcode = OPC_ITYPE;
      fetch(0);
      step("i_decode", DECODE, 1'b1);
      step("i_exec", EXEC_I, 1'b1);
      step("i_wb", ALU_WB, 1'b1);

      opcode = OPC_LOAD;
      fetch(0);
      step("ld_decode", DECODE, 1'b0);
      opcode = 7'b1111111;
      step("ld_addr", MEM_ADDR, 1'b0);
      for (int i = 0; i < 3; i++) step("ld_wait", MEM_RD, 1'b0);
      step("ld_rd", MEM_RD, 1'b1);
      step("ld_wb", MEM_WB, 1'b0);

      opcode = OPC_STORE;
      fetch(2);
      step("st_decode", DECODE, 1'b1);
      step("st_addr", MEM_ADDR, 1'b1);
      step("st_wait", MEM_WR, 1'b0);
      step("st_wr", MEM_WR, 1'b1);

      opcode = OPC_BRANCH;
      fetch(0);
      step("br_decode", DECODE, 1'b0);
      step("br_exec", BRANCH, 1'b1);

      opcode = 7'b1111111;
      fetch(0);
      step("ill_decode", DECODE, 1'b1);
      e_cause = CAUSE_ILLEGAL;
      for (int i = 0; i < 20; i++)
         step("ill_fault", FAULT, 1'($urandom_range(0, 1)));
      #2 reset = 1'b1;
      #1 chk("ill_async_rst", {15'd0, obs}, 32'd0);
      @(negedge clk);
      do_reset();

      step("to_start", START, 1'b0);
      for (int i = 0; i < 16; i++) step("to_fetch", FETCH, 1'b0);
      e_cause = CAUSE_TIMEOUT;
      for (int i = 0; i < 20; i++) step("to_fault", FAULT, 1'b0);
      chk("nto_mem_read", {31'd0, z_mrd}, 32'd1);
      chk("nto_fault", {31'd0, z_flt}, 32'd0);
      chk("nto_cause", {30'd0, z_cause}, 32'd0);
      #2 reset = 1'b1;
      #1 chk("nto_async_rd", {31'd0, z_mrd}, 32'd0);
      @(negedge clk);
      do_reset();

      step("end_start", START, 1'b1);
      opcode = OPC_BRANCH;
      fetch(1);
      step("end_decode", DECODE, 1'b1);
      step("end_br", BRANCH, 1'b0);
      step("end_fetch", FETCH, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle sequencer for the RV32 core datapath: one shared memory port, one ALU, and the IR/PC/ALUOut registers.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the datapath control strobes and waits on a memory ready handshake.
- Supports opcodes 0000011 (load), 0100011 (store), 0110011 (R-type), 0010011 (I-type ALU) and 1100011 (branch); any other opcode faults.

Parameters:
- MEM_TIMEOUT, 16: maximum number of consecutive cycles spent waiting on mem_ready before faulting; 0 disables the timeout.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  7  IR[6:0] from the datapath
- mem_ready  in  1  memory has completed the current read or write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by the datapath zero flag
- pc_source  out  1  0: ALU result; 1: ALUOut
- i_or_d  out  1  memory address select; 0: PC, 1: ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- reg_write  out  1  register file write
- mem_to_reg  out  1  writeback select; 1: MDR, 0: ALUOut
- alu_src_a  out  1  0: PC, 1: rs1
- alu_src_b  out  2  00: rs2, 01: constant 4, 10: immediate
- alu_op  out  2  00: add, 01: branch compare, 10: funct decode
- fault  out  1  sticky fault flag
- fault_cause  out  2  00: none, 01: illegal opcode, 10: memory timeout
- instret  out  CNT_W  retired-instruction count
- cycles  out  CNT_W  cycle count

Behaviour:
- Reset: async assert forces state START, clears the wait counter, the opcode latch and both counters. Every output is 0 during reset and in START.
- START: lasts one cycle, then goes to FETCH.
- Outputs are decoded from the state register. The only mem_ready-dependent outputs are ir_write and pc_write in FETCH.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - mem_ready=1: ir_write=1 and pc_write=1 in that same cycle; next state DECODE.
  - mem_ready=0: stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut). opcode is latched internally. Next state:
  - load or store: MEM_ADDR
  - 0110011: EXEC_R
  - 0010011: EXEC_I
  - 1100011: BRANCH
  - anything else: FAULT with cause 01
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEM_RD for a load, MEM_WR for a store (from the latched opcode).
- MEM_RD: mem_read=1, i_or_d=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1; next state FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Waits for mem_ready, then FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; next state ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00; next state ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0; next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1; next state FETCH.
- Wait counter (FETCH, MEM_RD, MEM_WR):
  - increments each cycle mem_ready=0; clears on mem_ready=1 and on any state change.
  - Reaching MEM_TIMEOUT while mem_ready is still 0 goes to FAULT with cause 10, and no strobe is issued in that cycle.
- FAULT: all strobes 0, fault=1, fault_cause held. Only reset leaves FAULT.
- A mem_ready pulse in a non-waiting state is ignored.
- Reset asserted mid-access drops mem_read/mem_write asynchronously.
- Latency in cycles, zero memory wait:
  - load 5
  - store 4
  - R-type 4
  - I-type 4
  - branch 3

Optional Feature:
PERF_CNT_EN
- Defined:
  - cycles increments every cycle when not in reset or FAULT.
  - instret increments on every transition into FETCH from MEM_WB, MEM_WR, ALU_WB or BRANCH.
  - Both counters wrap modulo 2^CNT_W.
- Undefined: instret and cycles are tied to 0 and no counter flops exist.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state encoding (START, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, FAULT)
  - opcode constants
  - alu_op and alu_src_b encodings
  - fault_cause codes
- One sub-module, mem_wait_timer: wait counter plus timeout compare, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset released, mem_ready tied 1, opcode 0110011: START, FETCH (ir_write=pc_write=1), DECODE, EXEC_R (alu_op=10), ALU_WB (reg_write=1), FETCH; instret=1 after 4 cycles past START.
- Load 0000011 with mem_ready held low 3 cycles in MEM_RD: mem_read=i_or_d=1 for 4 cycles, then MEM_WB with mem_to_reg=1; no timeout at MEM_TIMEOUT=16.
- Store 0100011: MEM_WR asserts mem_write=1 with reg_write=0 throughout; returns to FETCH on mem_ready.
- Branch 1100011: BRANCH cycle asserts pc_write_cond=1, pc_source=1, alu_op=01; 3-cycle instruction.
- Illegal opcode 1111111: FAULT after DECODE, fault=1, fault_cause=01, all strobes 0; persists 20 cycles; async reset clears everything.
- FETCH with mem_ready=0 for 16 cycles (MEM_TIMEOUT=16): FAULT, fault_cause=10, mem_read drops to 0; with MEM_TIMEOUT=0 it waits indefinitely.
